// File: rtl/mac_unit.sv
// Two-stage unsigned multiply-accumulate unit.
// Stage 1 registers the full-width product; stage 2 accumulates it, saturating or wrapping on overflow.
module mac_unit #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  out,
    output logic              out_valid,
    output logic              ovf
);

    localparam int unsigned PW  = 2 * DATA_W;
    localparam int unsigned EXT = ACC_W - PW + 1;

    logic [PW-1:0]    prod_d;
    logic [PW-1:0]    prod_q;
    logic             prod_v;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_d;
    logic             vld_d;

    // Operands widened before the multiply so no product bits are lost.
    assign prod_d = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q <= '0;
            prod_v <= 1'b0;
        end else begin
            prod_q <= prod_d;
            prod_v <= en;
        end
    end

    assign sum = {1'b0, acc} + {{EXT{1'b0}}, prod_q};

    always_comb begin
        acc_d = acc;
        ovf_d = ovf;
        vld_d = 1'b0;
        if (clr && prod_v) begin
            acc_d = {{(ACC_W - PW){1'b0}}, prod_q};
            ovf_d = 1'b0;
            vld_d = 1'b1;
        end else if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (prod_v) begin
            vld_d = 1'b1;
            if (sum[ACC_W]) begin
                ovf_d = 1'b1;
                acc_d = SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            acc       <= acc_d;
            ovf       <= ovf_d;
            out_valid <= vld_d;
        end
    end

    assign out = acc;

endmodule

// File: tb/tb_mac_unit.sv
// Directed bench for mac_unit: saturating and wrapping
// instances driven in lockstep.
module tb_mac_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] out_s;
    logic [15:0] out_w;
    logic        vld_s;
    logic        vld_w;
    logic        ovf_s;
    logic        ovf_w;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mac_unit #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
        .out(out_s), .out_valid(vld_s), .ovf(ovf_s)
    );

    mac_unit #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
        .out(out_w), .out_valid(vld_w), .ovf(ovf_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic c,
                         input logic [7:0] x, input logic [7:0] y);
        en  = e;
        clr = c;
        a   = x;
        b   = y;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0);
        #4;
        chk("rst_out", out_s, 0);
        chk("rst_vld", vld_s, 0);
        chk("rst_ovf", ovf_s, 0);
        #6;
        rst = 1'b1;

        // accumulate 15, 35, 290
        drive(1, 0, 5, 3);   tick();
        drive(1, 0, 10, 2);  tick();
        chk("acc1_out", out_s, 15);
        chk("acc1_vld", vld_s, 1);
        drive(1, 0, 255, 1); tick();
        chk("acc2_out", out_s, 35);
        chk("acc2_vld", vld_s, 1);
        drive(0, 0, 0, 0);   tick();
        chk("acc3_out", out_s, 290);
        chk("acc3_vld", vld_s, 1);
        chk("acc3_ovf", ovf_s, 0);
        tick();
        chk("acc4_vld", vld_s, 0);
        chk("acc4_out", out_s, 290);

        // bubbles
        drive(1, 1, 4, 4);   tick();
        chk("bub_clr", out_s, 0);
        drive(0, 0, 0, 0);   tick();
        chk("bub1_out", out_s, 16);
        chk("bub1_vld", vld_s, 1);
        tick();
        chk("bub2_out", out_s, 16);
        chk("bub2_vld", vld_s, 0);
        drive(1, 0, 2, 3);   tick();
        chk("bub3_out", out_s, 16);
        chk("bub3_vld", vld_s, 0);
        drive(0, 0, 0, 0);   tick();
        chk("bub4_out", out_s, 22);
        chk("bub4_vld", vld_s, 1);

        // saturation vs wrap
        drive(0, 1, 0, 0);   tick();
        chk("sclr_out", out_s, 0);
        drive(1, 0, 255, 255); tick();
        tick();
        chk("sat1_out", out_s, 65025);
        chk("wrp1_out", out_w, 65025);
        chk("sat1_ovf", ovf_s, 0);
        drive(1, 0, 1, 1);   tick();
        chk("sat2_out", out_s, 65535);
        chk("sat2_ovf", ovf_s, 1);
        chk("wrp2_out", out_w, 64514);
        chk("wrp2_ovf", ovf_w, 1);
        drive(0, 0, 0, 0);   tick();
        chk("sat3_out", out_s, 65535);
        chk("sat3_ovf", ovf_s, 1);
        chk("wrp3_out", out_w, 64515);
        chk("wrp3_ovf", ovf_w, 1);

        // clear with and without product in flight
        drive(0, 1, 0, 0);   tick();
        chk("clr1_out", out_s, 0);
        chk("clr1_ovf", ovf_s, 0);
        chk("clr1_ovfw", ovf_w, 0);
        chk("clr1_vld", vld_s, 0);
        drive(1, 0, 5, 3);   tick();
        drive(1, 0, 10, 2);  tick();
        drive(0, 0, 0, 0);   tick();
        chk("clr2_out", out_s, 35);
        drive(0, 1, 0, 0);   tick();
        chk("clr3_out", out_s, 0);
        drive(1, 0, 6, 7);   tick();
        drive(0, 1, 0, 0);   tick();
        chk("clrld_out", out_s, 42);
        chk("clrld_vld", vld_s, 1);
        chk("clrld_ovf", ovf_s, 0);

        // async reset between edges
        drive(1, 1, 5, 3);   tick();
        drive(1, 0, 10, 2);  tick();
        drive(1, 0, 255, 1); tick();
        drive(0, 0, 0, 0);   tick();
        chk("pre_rst", out_s, 290);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out", out_s, 0);
        chk("arst_outw", out_w, 0);
        chk("arst_vld", vld_s, 0);
        chk("arst_ovf", ovf_s, 0);
        #1;
        rst = 1'b1;
        drive(1, 0, 2, 3);   tick();
        chk("rel0_out", out_s, 0);
        drive(0, 0, 0, 0);   tick();
        chk("rel_out", out_s, 6);
        chk("rel_vld", vld_s, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
